// File: rtl/pll_phase_scan_monitor.sv
// ---------------------------------------------------------------------------
// pll_phase_scan_monitor
//
// Per-phase link-quality monitor sitting behind the PLL phase sweeper. While
// the sweeper dwells on a phase, this block blanks for SETTLE_CYCLES after
// every phase change and then counts checked samples and erroneous samples
// into a bin per phase. When a complete 0->1->2->3->0 sweep wraps, the four
// bins are walked one per cycle and the phase with the fewest errors is
// chosen. The live counters are copied to a snapshot for firmware readout.
// Partial or out-of-order sweeps are discarded.
//
// Parameters
//   SETTLE_CYCLES  blanking cycles after each phase change (>= 1)
//   CNT_W          width of the per-bin sample and error counters
//
// Ports
//   clk           system clock, shared with the sweeper
//   reset         synchronous, active-high
//   pll_phase     current phase index from the sweeper (quasi-static)
//   sample_valid  one data sample was checked this cycle
//   sample_err    that sample mismatched (qualified by sample_valid)
//   clear         synchronous clear of live counters, snapshot and result
//   rd_addr       snapshot bin select
//   rd_samples    snapshot sample count of bin rd_addr (combinational read)
//   rd_errors     snapshot error count of bin rd_addr (combinational read)
//   best_phase    phase with the fewest errors in the last complete sweep
//   best_valid    best_phase is meaningful (some bin had samples)
//   sweep_done    one-cycle pulse when snapshot and best result update
// ---------------------------------------------------------------------------
module pll_phase_scan_monitor #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       pll_phase,
  input  logic             sample_valid,
  input  logic             sample_err,
  input  logic             clear,
  input  logic [1:0]       rd_addr,
  output logic [CNT_W-1:0] rd_samples,
  output logic [CNT_W-1:0] rd_errors,
  output logic [1:0]       best_phase,
  output logic             best_valid,
  output logic             sweep_done
);

  // The settle counter only needs to reach SETTLE_CYCLES-1: the cycle on
  // which it sits at that value is the last blanked cycle.
  localparam int               SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_EVAL   = 2'd2
  } state_e;

  // FSM and phase tracking
  state_e           state_q,      state_d;
  logic [1:0]       phase_q,      phase_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [3:0]       visited_q,    visited_d;

  // Live counters and the firmware-visible snapshot
  logic [CNT_W-1:0] live_samples_q [4];
  logic [CNT_W-1:0] live_samples_d [4];
  logic [CNT_W-1:0] live_errors_q  [4];
  logic [CNT_W-1:0] live_errors_d  [4];
  logic [CNT_W-1:0] snap_samples_q [4];
  logic [CNT_W-1:0] snap_samples_d [4];
  logic [CNT_W-1:0] snap_errors_q  [4];
  logic [CNT_W-1:0] snap_errors_d  [4];

  // Evaluation walk: current bin and the running best candidate
  logic [1:0]       eval_idx_q,   eval_idx_d;
  logic             cand_found_q, cand_found_d;
  logic [1:0]       cand_idx_q,   cand_idx_d;
  logic [CNT_W-1:0] cand_err_q,   cand_err_d;

  // Registered results
  logic [1:0]       best_phase_q, best_phase_d;
  logic             best_valid_q, best_valid_d;
  logic             sweep_done_q, sweep_done_d;

  // Combinational helpers
  logic             chg;
  logic             wrap;
  logic             cur_has;
  logic             cur_wins;
  logic             clear_live;

  assign chg  = (pll_phase != phase_q);
  assign wrap = (phase_q == 2'd3) && (pll_phase == 2'd0);

  // A bin takes the lead only on strictly fewer errors, so on a tie the
  // lower index (visited first) keeps it.
  assign cur_has  = (live_samples_q[eval_idx_q] != '0);
  assign cur_wins = cur_has &&
                    (!cand_found_q || (live_errors_q[eval_idx_q] < cand_err_q));

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    phase_d        = pll_phase;
    settle_cnt_d   = settle_cnt_q;
    visited_d      = visited_q;
    live_samples_d = live_samples_q;
    live_errors_d  = live_errors_q;
    snap_samples_d = snap_samples_q;
    snap_errors_d  = snap_errors_q;
    eval_idx_d     = eval_idx_q;
    cand_found_d   = cand_found_q;
    cand_idx_d     = cand_idx_q;
    cand_err_d     = cand_err_q;
    best_phase_d   = best_phase_q;
    best_valid_d   = best_valid_q;
    sweep_done_d   = 1'b0;
    clear_live     = 1'b0;

    unique case (state_q)
      ST_SETTLE: begin
        if (chg) begin
          // Phase moved again before settling: blank the new phase afresh.
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          visited_d[phase_q] = 1'b1;
          settle_cnt_d       = '0;
          state_d            = ST_ACCUM;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end

      ST_ACCUM: begin
        // A sample on the change cycle still belongs to the old bin, which
        // is why the bin index is phase_q rather than pll_phase.
        if (sample_valid) begin
          if (live_samples_q[phase_q] != CNT_MAX) begin
            live_samples_d[phase_q] = live_samples_q[phase_q] + CNT_W'(1);
          end
          if (sample_err && (live_errors_q[phase_q] != CNT_MAX)) begin
            live_errors_d[phase_q] = live_errors_q[phase_q] + CNT_W'(1);
          end
        end
        if (chg) begin
          settle_cnt_d = '0;
          if (wrap && (&visited_q)) begin
            state_d      = ST_EVAL;
            eval_idx_d   = 2'd0;
            cand_found_d = 1'b0;
            cand_idx_d   = 2'd0;
            cand_err_d   = '0;
          end else begin
            // Non-wrapping moves leave skipped bins unvisited; a wrap with a
            // hole means the sweep was incomplete and is thrown away.
            state_d = ST_SETTLE;
            if (wrap) begin
              clear_live = 1'b1;
            end
          end
        end
      end

      ST_EVAL: begin
        if (cur_wins) begin
          cand_idx_d = eval_idx_q;
          cand_err_d = live_errors_q[eval_idx_q];
        end
        cand_found_d = cand_found_q | cur_has;
        eval_idx_d   = eval_idx_q + 2'd1;

        if (eval_idx_q == 2'd3) begin
          // Last bin folds straight into the published result. phase_q has
          // kept tracking pll_phase, so SETTLE begins on the current phase.
          snap_samples_d = live_samples_q;
          snap_errors_d  = live_errors_q;
          best_phase_d   = cur_wins ? eval_idx_q : cand_idx_q;
          best_valid_d   = cand_found_q | cur_has;
          sweep_done_d   = 1'b1;
          clear_live     = 1'b1;
          settle_cnt_d   = '0;
          state_d        = ST_SETTLE;
        end
      end

      default: begin
        state_d      = ST_SETTLE;
        settle_cnt_d = '0;
      end
    endcase

    if (clear_live) begin
      visited_d = '0;
      for (int b = 0; b < 4; b++) begin
        live_samples_d[b] = '0;
        live_errors_d[b]  = '0;
      end
    end
  end

  // NOTE: the counter and snapshot arrays are reset along with everything
  // else because firmware can read the snapshot straight after reset.
  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q      <= ST_SETTLE;
      phase_q      <= pll_phase;
      settle_cnt_q <= '0;
      visited_q    <= '0;
      eval_idx_q   <= 2'd0;
      cand_found_q <= 1'b0;
      cand_idx_q   <= 2'd0;
      cand_err_q   <= '0;
      best_phase_q <= 2'd0;
      best_valid_q <= 1'b0;
      sweep_done_q <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        live_samples_q[b] <= '0;
        live_errors_q[b]  <= '0;
        snap_samples_q[b] <= '0;
        snap_errors_q[b]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      settle_cnt_q   <= settle_cnt_d;
      visited_q      <= visited_d;
      eval_idx_q     <= eval_idx_d;
      cand_found_q   <= cand_found_d;
      cand_idx_q     <= cand_idx_d;
      cand_err_q     <= cand_err_d;
      best_phase_q   <= best_phase_d;
      best_valid_q   <= best_valid_d;
      sweep_done_q   <= sweep_done_d;
      live_samples_q <= live_samples_d;
      live_errors_q  <= live_errors_d;
      snap_samples_q <= snap_samples_d;
      snap_errors_q  <= snap_errors_d;
    end
  end

  assign rd_samples = snap_samples_q[rd_addr];
  assign rd_errors  = snap_errors_q[rd_addr];
  assign best_phase = best_phase_q;
  assign best_valid = best_valid_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: doc/pll_phase_scan_monitor.md
# pll_phase_scan_monitor

Per-phase link-quality monitor downstream of the PLL phase sweeper. It watches the 2-bit `pll_phase` index that the sweeper advances, ignores samples while the PLL settles, then counts valid and erroneous samples for each phase bin. After a complete 0→1→2→3→0 sweep it snapshots the four bins and selects the best phase (fewest errors) for firmware readout and later phase locking.

## Interface
Parameters:
- `SETTLE_CYCLES`, 1024: clk cycles of blanking after every phase change; must be ≥1.
- `CNT_W`, 24: width of per-bin sample and error counters.

Ports:
- `clk`  in  1  system clock; same clock as the sweeper.
- `reset`  in  1  synchronous, active-high.
- `pll_phase`  in  2  current phase index from the sweeper; quasi-static.
- `sample_valid`  in  1  one data sample checked this cycle.
- `sample_err`  in  1  that sample mismatched; qualified by `sample_valid`.
- `clear`  in  1  synchronous clear of live counters and results.
- `rd_addr`  in  2  snapshot bin select.
- `rd_samples`  out  CNT_W  snapshot sample count of bin `rd_addr`; combinational read.
- `rd_errors`  out  CNT_W  snapshot error count of bin `rd_addr`; combinational read.
- `best_phase`  out  2  phase with the fewest errors in the last complete sweep.
- `best_valid`  out  1  `best_phase` is meaningful.
- `sweep_done`  out  1  one-cycle pulse when the snapshot and best result update.

## Operation
- Registered `phase_q` holds the previous `pll_phase`. `chg = (pll_phase != phase_q)`.
- States: SETTLE, ACCUM, EVAL.
- SETTLE: the settle counter counts up to `SETTLE_CYCLES`. On reaching it, set `visited[phase_q]` and go to ACCUM. `chg` during SETTLE restarts the counter for the new phase.
- ACCUM: on `sample_valid`, increment `live_samples[phase_q]`. If `sample_err` is also high, increment `live_errors[phase_q]`. Both counters saturate at 2^CNT_W−1 with no wrap.
- `chg` in ACCUM:
  - Wrap (`phase_q`=3, `pll_phase`=0) with all four `visited` bits set: go to EVAL.
  - Wrap with any `visited` bit clear: partial sweep. Clear live counters and `visited`, then go to SETTLE.
  - Any other change, including non-sequential jumps: go to SETTLE. The skipped bin stays unvisited, so the sweep is later discarded.
- Samples arriving in SETTLE or EVAL are ignored.
- EVAL: walk bins 0..3, one per cycle.
  - Skip bins with `live_samples` = 0.
  - A bin wins on strictly fewer errors, so ties go to the lower index.
  - After bin 3, in one cycle:
    - copy the live counters to the snapshot;
    - load `best_phase`;
    - set `best_valid` = (any bin had samples);
    - pulse `sweep_done`;
    - clear live counters and `visited`;
    - go to SETTLE for the current `pll_phase`.
- `chg` during EVAL is not lost. `phase_q` keeps updating, and SETTLE starts on the phase current at EVAL exit.
- `clear` has the same effect as `reset` on counters, snapshot, `visited`, `best_phase`/`best_valid`, and state. It does not assert `sweep_done`.
- `reset` and `clear` have priority over all other activity, including mid-EVAL.

## Timing
- Reset values:
  - `best_phase` = 0, `best_valid` = 0, `sweep_done` = 0;
  - all counters and snapshots 0, so `rd_samples` = `rd_errors` = 0;
  - `visited` = 0;
  - state = SETTLE with the counter at 0;
  - `phase_q` loads `pll_phase` on the reset cycle, so no false `chg` fires after reset.
- `chg` is visible the cycle `pll_phase` changes. The first counted sample is the one arriving `SETTLE_CYCLES` + 1 cycles after the change.
- Wrap seen at cycle T: EVAL runs T+1..T+4. Snapshot, `best_*`, and the `sweep_done` pulse take effect at T+5, and the new SETTLE starts at T+5.
- A `sample_valid` on the same cycle as `chg` in ACCUM is counted into the old bin (`phase_q`).
- Snapshot reads are combinational from registers, with no read latency.

## Test plan
- Reset with `pll_phase` = 0 and `SETTLE_CYCLES` = 16, then sweep 0→1→2→3→0 with 1000 cycles per phase and `sample_valid` = 1 throughout. Inject errors: bin 0 = 50, bin 1 = 0, bin 2 = 7, bin 3 = 200. Expect the following:
  - `sweep_done` = 1 exactly at wrap+5;
  - `best_phase` = 1 and `best_valid` = 1;
  - `rd_samples` = 984 per bin and `rd_errors` = 50/0/7/200.
- Sweep with bins 1 and 2 both at 3 errors and the rest higher. Expect `best_phase` = 1 (tie goes to the lower index).
- Sweep 0→1→3→0, skipping phase 2. Expect no `sweep_done`, an unchanged snapshot, and `best_valid` still 0.
- Sweep with `sample_valid` held low throughout. Expect `sweep_done` to pulse, `best_valid` = 0, and all snapshot counts 0.
- Run with `CNT_W` = 4 and 40 errored samples in one bin. Expect `rd_errors` = 15 and `rd_samples` = 15 (saturated, no wrap).
- Assert `clear` mid-ACCUM after one complete sweep, with `best_valid` = 1. Expect, on the next cycle, `best_valid` = 0, reads of 0, and no `sweep_done`. A following full sweep then produces normal results.
